// File: rtl/fdtd_pkg.sv
// Shared constants and the probe recorder state encoding.
// The register block imports rec_state_t for status readback.
package fdtd_pkg;

    localparam int DEF_FDTD_DATA_WIDTH = 32;
    localparam int DEF_REG_SIZE_WIDTH  = 15;
    localparam int DEF_STEP_WIDTH      = 16;
    localparam int DEF_FIFO_DEPTH      = 8;

    typedef enum logic [1:0] {
        REC_IDLE  = 2'd0,
        REC_ARMED = 2'd1,
        REC_DRAIN = 2'd2,
        REC_DONE  = 2'd3
    } rec_state_t;

endpackage

// File: rtl/fdtd_probe_recorder_if.sv
// Memory write port between the probe recorder (master) and the memory controller (slave).
// wr_req_o, wr_addr_o and wr_data_o hold steady until a cycle where wr_req_o & wr_gnt_i; that cycle is the transfer.
interface fdtd_probe_recorder_if #(
    parameter int DATA_W = 32
);
    logic              wr_req_o;
    logic [31:0]       wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              wr_gnt_i;

    modport master (
        output wr_req_o,
        output wr_addr_o,
        output wr_data_o,
        input  wr_gnt_i
    );

    modport slave (
        input  wr_req_o,
        input  wr_addr_o,
        input  wr_data_o,
        output wr_gnt_i
    );
endinterface

// File: rtl/fdtd_sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry is visible on rdata_o.
// A push while full is accepted only when a pop happens in the same cycle.
module fdtd_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/fdtd_probe_recorder.sv
// Captures one Ez sample per FDTD time step at a chosen cell and streams the samples
// to consecutive memory words through a req/gnt write port.
module fdtd_probe_recorder
    import fdtd_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH = DEF_FDTD_DATA_WIDTH,
    parameter int REG_SIZE_WIDTH  = DEF_REG_SIZE_WIDTH,
    parameter int STEP_WIDTH      = DEF_STEP_WIDTH,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          start_i,
    input  logic                          clr_i,
    input  logic [31:0]                   base_addr_i,
    input  logic [STEP_WIDTH-1:0]         num_steps_i,
    input  logic [REG_SIZE_WIDTH-1:0]     sample_point_i,
    input  logic                          ez_valid_i,
    input  logic [REG_SIZE_WIDTH-1:0]     ez_idx_i,
    input  logic [FDTD_DATA_WIDTH-1:0]    ez_data_i,
    input  logic                          step_end_i,
    fdtd_probe_recorder_if.master         wr_if,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o,
    output logic                          miss_o,
    output logic [STEP_WIDTH-1:0]         samples_written_o,
    output rec_state_t                    state_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [31:0]               base_q, base_d;
    logic [STEP_WIDTH-1:0]     num_q, num_d;
    logic [REG_SIZE_WIDTH-1:0] sp_q, sp_d;
    logic [STEP_WIDTH-1:0]     step_cnt_q, step_cnt_d;
    logic [STEP_WIDTH-1:0]     wr_cnt_q, wr_cnt_d;
    logic                      captured_q, captured_d;
    logic                      overflow_q, overflow_d;
    logic                      miss_q, miss_d;

    logic                       capture;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [FDTD_DATA_WIDTH-1:0] fifo_head;
    logic [STEP_WIDTH-1:0]      step_next;

    fdtd_sync_fifo #(
        .WIDTH (FDTD_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .push_i  (capture),
        .wdata_i (ez_data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    assign wr_if.wr_req_o  = !fifo_empty && (state_q == S_ARMED || state_q == S_DRAIN);
    assign wr_if.wr_data_o = fifo_head;
    assign wr_if.wr_addr_o = base_q + (32'(wr_cnt_q) << 2);
    assign fifo_pop        = wr_if.wr_req_o && wr_if.wr_gnt_i;
    assign step_next       = step_cnt_q + 1'b1;

    assign busy_o            = (state_q == S_ARMED) || (state_q == S_DRAIN);
    assign done_o            = (state_q == S_DONE);
    assign overflow_o        = overflow_q;
    assign miss_o            = miss_q;
    assign samples_written_o = wr_cnt_q;
    assign state_o           = rec_state_t'(state_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        sp_d       = sp_q;
        step_cnt_d = step_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        captured_d = captured_q;
        overflow_d = overflow_q;
        miss_d     = miss_q;
        capture    = 1'b0;

        if (fifo_pop) wr_cnt_d = wr_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    num_d      = num_steps_i;
                    sp_d       = sample_point_i;
                    step_cnt_d = '0;
                    wr_cnt_d   = '0;
                    captured_d = 1'b0;
                    overflow_d = 1'b0;
                    miss_d     = 1'b0;
                    state_d    = (num_steps_i == '0) ? S_DONE : S_ARMED;
                end
            end
            S_ARMED: begin
                capture = ez_valid_i && (ez_idx_i == sp_q) && !captured_q;
                // A full FIFO drops the sample; the slot address is only consumed on a grant.
                if (capture && fifo_full && !fifo_pop) overflow_d = 1'b1;
                if (step_end_i) begin
                    step_cnt_d = step_next;
                    captured_d = 1'b0;
                    if (!captured_q && !capture) miss_d = 1'b1;
                    if (step_next == num_q) state_d = S_DRAIN;
                end else begin
                    captured_d = captured_q || capture;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) state_d = S_DONE;
            end
            default: begin
                if (clr_i) begin
                    state_d    = S_IDLE;
                    overflow_d = 1'b0;
                    miss_d     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            sp_q       <= '0;
            step_cnt_q <= '0;
            wr_cnt_q   <= '0;
            captured_q <= 1'b0;
            overflow_q <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            sp_q       <= sp_d;
            step_cnt_q <= step_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            captured_q <= captured_d;
            overflow_q <= overflow_d;
            miss_q     <= miss_d;
        end
    end
endmodule

// File: tb/tb_fdtd_probe_recorder.sv
// Directed bench for fdtd_probe_recorder: expected memory writes are queued as samples
// are captured and checked by a write-port monitor.
module tb_fdtd_probe_recorder;
  import fdtd_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        start_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] num_steps_i = '0;
  logic [14:0] sample_point_i = '0;
  logic        ez_valid_i = 1'b0;
  logic [14:0] ez_idx_i = '0;
  logic [31:0] ez_data_i = '0;
  logic        step_end_i = 1'b0;
  logic        wr_gnt = 1'b1;
  logic        busy_o, done_o, overflow_o, miss_o;
  logic [15:0] samples_written_o;
  rec_state_t  state_o;
  logic [3:0]  fifo_count_o;

  fdtd_probe_recorder_if #(.DATA_W(32)) wr_if ();
  assign wr_if.wr_gnt_i = wr_gnt;

  fdtd_probe_recorder dut (
    .ACLK              (ACLK),
    .ARESETn           (ARESETn),
    .start_i           (start_i),
    .clr_i             (clr_i),
    .base_addr_i       (base_addr_i),
    .num_steps_i       (num_steps_i),
    .sample_point_i    (sample_point_i),
    .ez_valid_i        (ez_valid_i),
    .ez_idx_i          (ez_idx_i),
    .ez_data_i         (ez_data_i),
    .step_end_i        (step_end_i),
    .wr_if             (wr_if),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .overflow_o        (overflow_o),
    .miss_o            (miss_o),
    .samples_written_o (samples_written_o),
    .state_o           (state_o),
    .fifo_count_o      (fifo_count_o)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: write-port monitor with stability checking while stalled
  logic        hold = 1'b0;
  logic [31:0] hold_addr, hold_data;
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_req", 64'(wr_if.wr_req_o), 64'd1);
        check("stall_addr", 64'(wr_if.wr_addr_o), 64'(hold_addr));
        check("stall_data", 64'(wr_if.wr_data_o), 64'(hold_data));
      end
      hold = wr_if.wr_req_o && !wr_gnt;
      hold_addr = wr_if.wr_addr_o;
      hold_data = wr_if.wr_data_o;
      if (wr_if.wr_req_o && wr_gnt) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {wr_if.wr_addr_o, wr_if.wr_data_o}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          check("write", {wr_if.wr_addr_o, wr_if.wr_data_o}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start_rec(input logic [31:0] base, input logic [15:0] n, input logic [14:0] sp);
    base_addr_i = base;
    num_steps_i = n;
    sample_point_i = sp;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic beat(input logic [14:0] idx, input logic [31:0] data, input logic se);
    ez_valid_i = 1'b1;
    ez_idx_i = idx;
    ez_data_i = data;
    step_end_i = se;
    tick();
    ez_valid_i = 1'b0;
    step_end_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && !done_o; i++) tick();
    check(tag, 64'(done_o), 64'd1);
  endtask

  initial begin
    tick();
    tick();
    check("reset_req", 64'(wr_if.wr_req_o), 64'd0);
    check("reset_flags", {busy_o, done_o, overflow_o, miss_o}, 64'd0);
    check("reset_samples", 64'(samples_written_o), 64'd0);
    ARESETn = 1'b1;
    tick();

    // basic three steps, grant always high
    wr_gnt = 1'b1;
    start_rec(32'h1000, 16'd3, 15'd5);
    check("t1_busy", 64'(busy_o), 64'd1);
    for (int s = 0; s < 3; s++) begin
      beat(15'd3, 32'hFFFF_0000, 1'b0);
      beat(15'd5, 32'hA + 32'(s), 1'b0);
      exp_q.push_back({32'h1000 + 32'(4 * s), 32'hA + 32'(s)});
      check("t1_latency_req", 64'(wr_if.wr_req_o), 64'd1);
      beat(15'd7, 32'hFFFF_0001, 1'b1);
    end
    wait_done("t1_done", 20);
    check("t1_samples", 64'(samples_written_o), 64'd3);
    check("t1_flags", {overflow_o, miss_o}, 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    pulse_clr();
    check("t1_clr_state", 64'(state_o), 64'(REC_IDLE));

    // duplicate beat in step 1, no beat in step 2
    start_rec(32'h4000, 16'd2, 15'd5);
    beat(15'd5, 32'h11, 1'b0);
    exp_q.push_back({32'h4000, 32'h11});
    beat(15'd5, 32'h22, 1'b0);
    beat(15'd1, 32'h0, 1'b1);
    beat(15'd4, 32'h33, 1'b0);
    beat(15'd2, 32'h0, 1'b1);
    wait_done("t2_done", 20);
    check("t2_miss", 64'(miss_o), 64'd1);
    check("t2_samples", 64'(samples_written_o), 64'd1);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    pulse_clr();
    check("t2_clr_flags", {done_o, miss_o, overflow_o}, 64'd0);

    // backpressure: 10 samples into an 8-deep FIFO with grant low
    wr_gnt = 1'b0;
    start_rec(32'h8000, 16'd10, 15'd9);
    for (int s = 0; s < 10; s++) begin
      beat(15'd9, 32'h100 + 32'(s), 1'b0);
      if (s < 8) exp_q.push_back({32'h8000 + 32'(4 * s), 32'h100 + 32'(s)});
      if (s == 0) begin
        check("t3_first_req", 64'(wr_if.wr_req_o), 64'd1);
        check("t3_first_addr", 64'(wr_if.wr_addr_o), 64'h8000);
      end
      beat(15'd2, 32'h0, 1'b1);
    end
    check("t3_overflow", 64'(overflow_o), 64'd1);
    check("t3_state_drain", 64'(state_o), 64'(REC_DRAIN));
    check("t3_fifo_full", 64'(fifo_count_o), 64'd8);
    wr_gnt = 1'b1;
    wait_done("t3_done", 30);
    check("t3_samples", 64'(samples_written_o), 64'd8);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    pulse_clr();
    check("t3_clr_flags", {done_o, overflow_o}, 64'd0);

    // capture and step end in the same cycle on the last step
    wr_gnt = 1'b0;
    start_rec(32'h0000_0100, 16'd1, 15'd2);
    beat(15'd2, 32'h55, 1'b1);
    exp_q.push_back({32'h100, 32'h55});
    check("t4_state_drain", 64'(state_o), 64'(REC_DRAIN));
    check("t4_req", 64'(wr_if.wr_req_o), 64'd1);
    wr_gnt = 1'b1;
    wait_done("t4_done", 10);
    check("t4_samples", 64'(samples_written_o), 64'd1);
    check("t4_miss", 64'(miss_o), 64'd0);
    pulse_clr();

    // zero steps goes straight to DONE
    start_rec(32'h2000, 16'd0, 15'd1);
    check("t5_done_next", 64'(done_o), 64'd1);
    check("t5_no_req", 64'(wr_if.wr_req_o), 64'd0);
    check("t5_samples", 64'(samples_written_o), 64'd0);
    pulse_clr();

    // start and clr while ARMED are ignored
    start_rec(32'h2000, 16'd2, 15'd3);
    start_rec(32'h3000, 16'd1, 15'd4);
    pulse_clr();
    check("t6_still_armed", 64'(state_o), 64'(REC_ARMED));
    beat(15'd4, 32'h66, 1'b0);
    beat(15'd3, 32'h77, 1'b1);
    exp_q.push_back({32'h2000, 32'h77});
    check("t6_after_step1", 64'(state_o), 64'(REC_ARMED));
    beat(15'd3, 32'h88, 1'b1);
    exp_q.push_back({32'h2004, 32'h88});
    wait_done("t6_done", 10);
    check("t6_samples", 64'(samples_written_o), 64'd2);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    pulse_clr();

    // asynchronous reset during DRAIN with a pending request
    wr_gnt = 1'b0;
    start_rec(32'h5000, 16'd1, 15'd1);
    beat(15'd1, 32'h99, 1'b1);
    check("t7_pending_req", 64'(wr_if.wr_req_o), 64'd1);
    ARESETn = 1'b0;
    #1;
    exp_q.delete();
    check("t7_rst_req", 64'(wr_if.wr_req_o), 64'd0);
    check("t7_rst_flags", {busy_o, done_o, overflow_o, miss_o}, 64'd0);
    check("t7_rst_samples", 64'(samples_written_o), 64'd0);
    tick();
    ARESETn = 1'b1;
    tick();
    check("t7_fifo_empty", 64'(fifo_count_o), 64'd0);
    check("t7_state_idle", 64'(state_o), 64'(REC_IDLE));
    check("t7_req_after", 64'(wr_if.wr_req_o), 64'd0);
    wr_gnt = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fdtd_probe_recorder.md
Name: fdtd_probe_recorder

Overview:
- Sits downstream of the 1-D FDTD accelerator.
- Watches the updated Ez stream for the configured sample_point cell and captures one Ez value per time step into a small FIFO.
- Drains captured samples to data memory through a simple req/gnt write port; the memory controller arbitrates this port onto the AXI master.
- Reports done/overflow/miss status to the register block, which raises the interrupt.

Parameters:
FDTD_DATA_WIDTH, 32, width of Ez samples and memory data
REG_SIZE_WIDTH, 15, width of cell index / sample_point
STEP_WIDTH, 16, width of time-step counter
FIFO_DEPTH, 8, capture FIFO entries; power of two, at least 2

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset, asynchronous, active-low
start_i  in  1  pulse; arms recorder (ignored unless IDLE)
clr_i  in  1  pulse; DONE -> IDLE, clears sticky flags
base_addr_i  in  32  byte address of first sample slot (word aligned)
num_steps_i  in  STEP_WIDTH  time steps to record
sample_point_i  in  REG_SIZE_WIDTH  cell index to probe
ez_valid_i  in  1  Ez_n stream beat valid
ez_idx_i  in  REG_SIZE_WIDTH  cell index of beat
ez_data_i  in  FDTD_DATA_WIDTH  updated Ez value
step_end_i  in  1  pulse; current time step finished
wr_req_o  out  1  memory write request
wr_addr_o  out  32  write byte address
wr_data_o  out  FDTD_DATA_WIDTH  write data
wr_gnt_i  in  1  write accepted when wr_req_o & wr_gnt_i
busy_o  out  1  state is ARMED or DRAIN
done_o  out  1  state is DONE
overflow_o  out  1  sticky; a sample was dropped because the FIFO was full
miss_o  out  1  sticky; a step ended with no capture
samples_written_o  out  STEP_WIDTH  accepted memory writes since start

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, all counters 0. Reset mid-operation discards everything, including any pending request.
- FSM states: IDLE, ARMED, DRAIN, DONE.
- IDLE -> ARMED on start_i. This latches base_addr_i, num_steps_i and sample_point_i, and clears step_cnt, wr_cnt, the captured flag, overflow and miss.
- start_i with num_steps_i = 0 goes straight to DONE on the next cycle, with no writes.
- ARMED, capture: when ez_valid_i and ez_idx_i == latched sample_point and captured flag is 0, push ez_data_i and set captured.
  - Later matching beats in the same step are ignored.
- ARMED, step end: on step_end_i, step_cnt increments and captured clears.
  - If captured was 0 and no capture happens in the same cycle, set miss_o.
  - A capture in the same cycle as step_end_i belongs to the ending step.
- ARMED -> DRAIN when the incremented step_cnt equals num_steps. Captures stop from that cycle onward.
- DRAIN -> DONE when the FIFO is empty and no request is outstanding.
- DONE -> IDLE on clr_i. clr_i in other states has no effect. start_i while not IDLE is ignored.
- FIFO behaviour:
  - A push when full and not popping drops the sample and sets overflow_o. The address slot is not consumed, so stored samples stay contiguous.
  - Simultaneous push and pop when full succeeds.
- Write port:
  - wr_req_o is asserted whenever the FIFO is non-empty, in ARMED or DRAIN. Draining overlaps capture.
  - wr_data_o is the FIFO head; wr_addr_o = base + 4*wr_cnt (32-bit wrap, unchecked).
  - req/addr/data stay stable until the grant. On the grant, pop, wr_cnt++, and the next entry is presented the following cycle.
  - wr_gnt_i without wr_req_o is ignored.
- Latency: a capture in cycle N gives wr_req_o = 1 in cycle N+1 (FIFO registered), at best one write per cycle.
- samples_written_o = wr_cnt. It holds in DONE and clears on start_i.
- Arithmetic: step_cnt and wr_cnt are unsigned STEP_WIDTH. ez_data_i passes through unmodified.

Decomposition:
- fdtd_pkg holds FDTD_DATA_WIDTH, REG_SIZE_WIDTH and STEP_WIDTH defaults, plus the recorder state enum (rec_state_t) shared with the register block for status readback.
- Sub-module fdtd_sync_fifo: single-clock FIFO, parameterised width/depth, push/pop/full/empty/count, same reset. The recorder FSM and address generation stay in the top.

Test Plan:
- Basic 3 steps: base=0x1000, sample_point=5, num_steps=3, Ez at idx 5 = 0xA, 0xB, 0xC, gnt always 1 -> writes 0x1000=0xA, 0x1004=0xB, 0x1008=0xC; done_o=1, samples_written_o=3, miss_o=0, overflow_o=0.
- Duplicate and miss: step 1 has idx 5 twice (0x11, 0x22); step 2 has no idx 5 -> only 0x11 written; miss_o=1; samples_written_o=1.
- Backpressure/overflow: FIFO_DEPTH=8, gnt held 0 for 10 steps, then 1 -> first 8 samples written contiguously from base; overflow_o=1; req/addr/data stable while gnt=0.
- Boundary events: capture and step_end_i in the same cycle on the last step -> sample recorded, state DRAIN next cycle. num_steps=0 -> DONE in 1 cycle with no wr_req_o.
- Control misuse: start_i while ARMED ignored (latched values unchanged). clr_i in DONE -> IDLE with flags cleared. ARESETn asserted mid-DRAIN -> wr_req_o=0 immediately, all outputs 0, FIFO empty after release.
